tpu_uart_controller: RTL and testbench
======================================

Name: tpu_uart_controller

Overview:
- Host-facing command front end of the TPU: 8N1 UART receiver/transmitter plus byte-command parser.
- Turns host commands into weight-FIFO pushes, activation loads, MLP start and status/result readback.
- Sits between the board UART pins and the TPU bridge/MLP datapath.

Parameters:
CLOCK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, UART bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial input, idle high, asynchronous to clk
uart_tx  out  1  serial output, idle high
wf_push_col0  out  1  one-cycle push into weight FIFO column 0
wf_push_col1  out  1  one-cycle push into weight FIFO column 1
wf_data_in  out  8  weight byte, valid with push
wf_reset  out  1  one-cycle weight FIFO clear
init_act_valid  out  1  one-cycle initial activation strobe
init_act_data  out  16  activation word, valid with strobe
start_mlp  out  1  one-cycle MLP start
weights_ready  out  1  level: weights loaded
mlp_state  in  4  MLP FSM state
mlp_cycle_cnt  in  5  MLP cycle counter
mlp_acc0  in  32  signed accumulator 0
dbg_state  out  4  parser state
dbg_cmd_reg  out  8  latched opcode
dbg_byte_count  out  3  argument bytes received
dbg_resp_byte_idx  out  2  response byte index
dbg_tx_valid  out  1  internal TX request
dbg_tx_ready  out  1  TX idle
dbg_rx_valid  out  1  RX byte strobe
dbg_rx_data  out  8  last RX byte
dbg_weights_ready  out  1  copy of weights_ready
dbg_start_mlp  out  1  copy of start_mlp

Behaviour:
- Reset: uart_tx=1; all strobes, weights_ready, data/debug regs = 0; parser IDLE(0).
- RX: 2-FF synchronizer; falling edge starts frame; sample at mid-bit (CLKS_PER_BIT/2), then every CLKS_PER_BIT; LSB first; stop bit 0 = framing error, byte dropped. Valid byte -> dbg_rx_valid one-cycle pulse, dbg_rx_data updated.
- TX: accepts byte when tx_valid && tx_ready; start bit, 8 data LSB-first, 1 stop bit, each CLKS_PER_BIT clocks; tx_ready low while busy.
- Parser states: IDLE(0), GET_ARG(1), EXEC(2), SEND(3), WAIT_TX(4).
- IDLE: received byte latched in dbg_cmd_reg; byte_count cleared; opcodes with arguments -> GET_ARG, others -> EXEC; unknown opcode ignored, stays IDLE.
- Opcodes:
  - 0x01 WR_W0 (1 arg): wf_push_col0 pulse, wf_data_in=arg.
  - 0x02 WR_W1 (1 arg): wf_push_col1 pulse, wf_data_in=arg.
  - 0x03 WR_ACT (2 args, low byte then high): init_act_data={hi,lo}, init_act_valid pulse.
  - 0x04 SET_WREADY: weights_ready<=1.
  - 0x05 START: start_mlp pulse, only if weights_ready=1, else ignored.
  - 0x06 RD_STATUS: reply 2 bytes {4'b0,mlp_state}, {3'b0,mlp_cycle_cnt}.
  - 0x07 RD_ACC: reply 4 bytes of mlp_acc0, MSB first, snapshotted in EXEC.
  - 0x08 WF_RESET: wf_reset pulse; weights_ready<=0.
- Strobes assert exactly one cycle, in the EXEC cycle following the last argument byte.
- Read opcodes: EXEC -> SEND (present byte[dbg_resp_byte_idx]) -> WAIT_TX until tx_ready -> next index or IDLE.
- Bytes received during SEND/WAIT_TX are discarded.
- Reset mid-frame: RX/TX abort, uart_tx driven high immediately.

Optional Feature:
- Macro UART_CTRL_ACK_EN.
- Defined: after each non-read opcode executes (0x01-0x05, 0x08), transmit ack byte 0xAA via SEND/WAIT_TX before IDLE; ignored START still acks.
- Undefined: write opcodes produce no UART output.

Test Plan:
- CLOCK_FREQ=1_000_000, BAUD_RATE=100_000; send 0x01,0x5A -> single-cycle wf_push_col0 with wf_data_in=0x5A; col1 stays 0.
- Send 0x03,0x34,0x12 -> init_act_valid 1 cycle, init_act_data=0x1234.
- Send 0x05 with weights_ready=0 -> no start_mlp; then 0x04, 0x05 -> weights_ready=1, one start_mlp pulse.
- mlp_acc0=0xDEADBEEF, send 0x07 -> uart_tx frames 0xDE,0xAD,0xBE,0xEF, each 10 bit-times; mlp_state=3, cycle_cnt=17, send 0x06 -> 0x03,0x11.
- Frame with stop bit 0 -> no dbg_rx_valid, parser stays IDLE; 0x08 -> wf_reset pulse, weights_ready=0.
- Assert rst_n low mid-response -> uart_tx=1, dbg_state=0 immediately; next command works.

Source files
------------

// File: rtl/tpu_uart_controller_if.sv
// Datapath-side bundle of the UART command front end: weight FIFO, activations, MLP control/status.
// Latency: n/a (pure signal grouping, no logic).
// Backpressure: none; every strobe is a single-cycle push that the datapath must accept.
interface tpu_uart_controller_if;
    logic        wf_push_col0;
    logic        wf_push_col1;
    logic [7:0]  wf_data_in;
    logic        wf_reset;
    logic        init_act_valid;
    logic [15:0] init_act_data;
    logic        start_mlp;
    logic        weights_ready;
    logic [3:0]  mlp_state;
    logic [4:0]  mlp_cycle_cnt;
    logic [31:0] mlp_acc0;

    // Command front end drives the strobes and reads MLP status
    modport master (
        output wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
        output init_act_valid, init_act_data, start_mlp, weights_ready,
        input  mlp_state, mlp_cycle_cnt, mlp_acc0
    );

    // TPU bridge / MLP datapath side
    modport slave (
        input  wf_push_col0, wf_push_col1, wf_data_in, wf_reset,
        input  init_act_valid, init_act_data, start_mlp, weights_ready,
        output mlp_state, mlp_cycle_cnt, mlp_acc0
    );
endinterface

// File: rtl/tpu_uart_controller.sv
// 8N1 UART RX/TX plus byte-command parser driving weight FIFO, activation load, MLP start and readback.
// Latency: strobes fire one cycle after the last argument byte is sampled; replies start 2 cycles after EXEC.
// Backpressure: none on RX (bytes arriving while a reply is in flight are dropped); replies wait on TX idle.
// Optional: define UART_CTRL_ACK_EN to transmit an 0xAA ack after every non-read opcode.
module tpu_uart_controller #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    tpu_uart_controller_if.master bus,
    output logic [3:0]  dbg_state,
    output logic [7:0]  dbg_cmd_reg,
    output logic [2:0]  dbg_byte_count,
    output logic [1:0]  dbg_resp_byte_idx,
    output logic        dbg_tx_valid,
    output logic        dbg_tx_ready,
    output logic        dbg_rx_valid,
    output logic [7:0]  dbg_rx_data,
    output logic        dbg_weights_ready,
    output logic        dbg_start_mlp
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        P_IDLE = 4'd0, P_GET_ARG = 4'd1, P_EXEC = 4'd2, P_SEND = 4'd3, P_WAIT_TX = 4'd4
    } p_state_t;

    // RX side
    logic          rx_s1, rx_s2, rx_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_valid;
    logic [7:0]    rx_data;

    // TX side
    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;
    logic [8:0]    tx_shift;
    logic          tx_ready;

    // Parser
    p_state_t      state;
    logic [7:0]    cmd_reg;
    logic [2:0]    byte_count;
    logic [7:0]    arg_lo, arg_hi;
    logic [31:0]   resp_buf;
    logic [1:0]    resp_idx, resp_last;
    logic          tx_valid;
    logic [7:0]    tx_data;

    assign tx_ready          = ~tx_busy;
    assign dbg_state         = state;
    assign dbg_cmd_reg       = cmd_reg;
    assign dbg_byte_count    = byte_count;
    assign dbg_resp_byte_idx = resp_idx;
    assign dbg_tx_valid      = tx_valid;
    assign dbg_tx_ready      = tx_ready;
    assign dbg_rx_valid      = rx_valid;
    assign dbg_rx_data       = rx_data;
    assign dbg_weights_ready = bus.weights_ready;
    assign dbg_start_mlp     = bus.start_mlp;

    // RX: synchronise the pin, find the start edge, sample mid-bit, drop frames with a low stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_cnt   <= rx_cnt + 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_state <= RX_START;
                end
                RX_START: if (rx_cnt == BIT_HALF) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_cnt == BIT_LAST) begin
                    rx_state <= RX_IDLE;
                    if (rx_s2) begin
                        rx_valid <= 1'b1;
                        rx_data  <= rx_shift;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // TX: start bit on accept, then 8 data bits LSB first, then a stop bit; line rests high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else if (!tx_busy) begin
            if (tx_valid) begin
                uart_tx  <= 1'b0;
                tx_shift <= {1'b1, tx_data};
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
                tx_idx   <= '0;
            end
        end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                uart_tx  <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[8:1]};
                tx_idx   <= tx_idx + 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    // Parser FSM: collect opcode/arguments, fire one-cycle strobes in EXEC, stream replies byte by byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= P_IDLE;
            cmd_reg            <= '0;
            byte_count         <= '0;
            arg_lo             <= '0;
            arg_hi             <= '0;
            resp_buf           <= '0;
            resp_idx           <= '0;
            resp_last          <= '0;
            tx_valid           <= 1'b0;
            tx_data            <= '0;
            bus.wf_push_col0   <= 1'b0;
            bus.wf_push_col1   <= 1'b0;
            bus.wf_data_in     <= '0;
            bus.wf_reset       <= 1'b0;
            bus.init_act_valid <= 1'b0;
            bus.init_act_data  <= '0;
            bus.start_mlp      <= 1'b0;
            bus.weights_ready  <= 1'b0;
        end else begin
            bus.wf_push_col0   <= 1'b0;
            bus.wf_push_col1   <= 1'b0;
            bus.wf_reset       <= 1'b0;
            bus.init_act_valid <= 1'b0;
            bus.start_mlp      <= 1'b0;
            case (state)
                P_IDLE: if (rx_valid) begin
                    cmd_reg    <= rx_data;
                    byte_count <= '0;
                    case (rx_data)
                        8'h01, 8'h02, 8'h03:                 state <= P_GET_ARG;
                        8'h04, 8'h05, 8'h06, 8'h07, 8'h08:   state <= P_EXEC;
                        default:                             state <= P_IDLE;
                    endcase
                end
                P_GET_ARG: if (rx_valid) begin
                    if (byte_count == 3'd0) arg_lo <= rx_data;
                    else                    arg_hi <= rx_data;
                    byte_count <= byte_count + 1'b1;
                    // WR_ACT is the only two-argument opcode
                    if (cmd_reg != 8'h03 || byte_count == 3'd1) state <= P_EXEC;
                end
                P_EXEC: begin
                    resp_idx <= '0;
                    state    <= P_IDLE;
                    case (cmd_reg)
                        8'h01: begin bus.wf_push_col0 <= 1'b1; bus.wf_data_in <= arg_lo; end
                        8'h02: begin bus.wf_push_col1 <= 1'b1; bus.wf_data_in <= arg_lo; end
                        8'h03: begin
                            bus.init_act_valid <= 1'b1;
                            bus.init_act_data  <= {arg_hi, arg_lo};
                        end
                        8'h04: bus.weights_ready <= 1'b1;
                        8'h05: if (bus.weights_ready) bus.start_mlp <= 1'b1;
                        8'h06: begin
                            resp_buf  <= {4'b0, bus.mlp_state, 3'b0, bus.mlp_cycle_cnt, 16'h0000};
                            resp_last <= 2'd1;
                            state     <= P_SEND;
                        end
                        8'h07: begin
                            resp_buf  <= bus.mlp_acc0;
                            resp_last <= 2'd3;
                            state     <= P_SEND;
                        end
                        8'h08: begin bus.wf_reset <= 1'b1; bus.weights_ready <= 1'b0; end
                        default: ;
                    endcase
`ifdef UART_CTRL_ACK_EN
                    if (cmd_reg != 8'h06 && cmd_reg != 8'h07) begin
                        resp_buf  <= 32'hAA00_0000;
                        resp_last <= 2'd0;
                        state     <= P_SEND;
                    end
`endif
                end
                P_SEND: begin
                    tx_valid <= 1'b1;
                    tx_data  <= resp_buf[31:24];
                    state    <= P_WAIT_TX;
                end
                P_WAIT_TX: begin
                    if (tx_valid) begin
                        if (tx_ready) tx_valid <= 1'b0;
                    end else if (tx_ready) begin
                        if (resp_idx == resp_last) begin
                            state <= P_IDLE;
                        end else begin
                            resp_idx <= resp_idx + 1'b1;
                            resp_buf <= {resp_buf[23:0], 8'h00};
                            state    <= P_SEND;
                        end
                    end
                end
                default: state <= P_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_uart_controller.sv
// Directed bench for the UART command front end at 10 clocks per bit.
// Drives serial frames on uart_rx, decodes uart_tx frames, counts datapath strobes.
module tb_tpu_uart_controller;
    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic [3:0]  dbg_state;
    logic [7:0]  dbg_cmd_reg;
    logic [2:0]  dbg_byte_count;
    logic [1:0]  dbg_resp_byte_idx;
    logic        dbg_tx_valid, dbg_tx_ready, dbg_rx_valid;
    logic [7:0]  dbg_rx_data;
    logic        dbg_weights_ready, dbg_start_mlp;

    tpu_uart_controller_if bus();

    tpu_uart_controller #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx), .bus(bus),
        .dbg_state(dbg_state), .dbg_cmd_reg(dbg_cmd_reg), .dbg_byte_count(dbg_byte_count),
        .dbg_resp_byte_idx(dbg_resp_byte_idx), .dbg_tx_valid(dbg_tx_valid),
        .dbg_tx_ready(dbg_tx_ready), .dbg_rx_valid(dbg_rx_valid), .dbg_rx_data(dbg_rx_data),
        .dbg_weights_ready(dbg_weights_ready), .dbg_start_mlp(dbg_start_mlp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int c_push0 = 0, c_push1 = 0, c_act = 0, c_start = 0, c_wfrst = 0, c_rxv = 0;
    logic [7:0]  last_w0 = '0;
    logic [15:0] last_act = '0;
    logic [7:0]  tx_q[$];
    logic        stop_q[$];
    int          start_q[$];

    always @(posedge clk) cyc++;

    // Strobe counters: a one-cycle pulse adds exactly one per command
    always @(negedge clk) begin
        if (bus.wf_push_col0)   begin c_push0++; last_w0 = bus.wf_data_in; end
        if (bus.wf_push_col1)   c_push1++;
        if (bus.init_act_valid) begin c_act++; last_act = bus.init_act_data; end
        if (bus.start_mlp)      c_start++;
        if (bus.wf_reset)       c_wfrst++;
        if (dbg_rx_valid)       c_rxv++;
    end

    // Serial decoder for uart_tx
    initial begin
        logic [7:0] d;
        int t0;
        forever begin
            @(negedge uart_tx);
            if (rst_n) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                tx_q.push_back(d);
                stop_q.push_back(uart_tx);
                start_q.push_back(t0);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Long enough for an optional ack frame to finish before the next command
    task automatic settle();
        repeat (150) @(negedge clk);
    endtask

    task automatic clear_q();
        tx_q.delete();
        stop_q.delete();
        start_q.delete();
    endtask

    task automatic wait_frames(input string tag, input int n);
        for (int i = 0; i < 3000 && tx_q.size() < n; i++) @(negedge clk);
        chk(tag, tx_q.size(), n);
    endtask

    initial begin
        int p0, rx0, gap;
        int exp_ack;
`ifdef UART_CTRL_ACK_EN
        exp_ack = 1;
`else
        exp_ack = 0;
`endif
        bus.mlp_state = 4'd0;
        bus.mlp_cycle_cnt = 5'd0;
        bus.mlp_acc0 = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_state", dbg_state, 0);
        chk("rst_wready", bus.weights_ready, 0);
        chk("rst_wf_data", bus.wf_data_in, 0);
        chk("rst_act_data", bus.init_act_data, 0);
        chk("rst_tx_ready", dbg_tx_ready, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // WR_W0 0x5A
        send_byte(8'h01, 1'b1);
        send_byte(8'h5A, 1'b1);
        chk("w0_push_cnt", c_push0, 1);
        chk("w0_data", last_w0, 8'h5A);
        chk("w0_col1_cnt", c_push1, 0);
        chk("w0_cmd_reg", dbg_cmd_reg, 8'h01);
        chk("w0_state_idle", dbg_state, 0);
        settle();
        chk("w0_ack_frames", tx_q.size(), exp_ack);
        clear_q();

        // WR_ACT low then high
        send_byte(8'h03, 1'b1);
        send_byte(8'h34, 1'b1);
        chk("act_not_yet", c_act, 0);
        send_byte(8'h12, 1'b1);
        chk("act_cnt", c_act, 1);
        chk("act_data", last_act, 16'h1234);
        settle();

        // START without weights is ignored; then SET_WREADY and START
        send_byte(8'h05, 1'b1);
        chk("start_ignored", c_start, 0);
        settle();
        send_byte(8'h04, 1'b1);
        chk("wready_set", bus.weights_ready, 1);
        chk("dbg_wready", dbg_weights_ready, 1);
        settle();
        send_byte(8'h05, 1'b1);
        chk("start_cnt", c_start, 1);
        settle();
        clear_q();

        // RD_ACC: snapshot taken in EXEC, later changes must not leak into the reply
        bus.mlp_acc0 = 32'hDEADBEEF;
        send_byte(8'h07, 1'b1);
        bus.mlp_acc0 = 32'h0;
        wait_frames("acc_frames", 4);
        if (tx_q.size() >= 4) begin
            chk("acc_b0", tx_q[0], 8'hDE);
            chk("acc_b1", tx_q[1], 8'hAD);
            chk("acc_b2", tx_q[2], 8'hBE);
            chk("acc_b3", tx_q[3], 8'hEF);
            chk("acc_stop", {28'd0, stop_q[0], stop_q[1], stop_q[2], stop_q[3]}, 4'hF);
            gap = start_q[1] - start_q[0];
            chk("acc_gap_10bits", (gap >= 10 * CPB && gap <= 10 * CPB + 10) ? 1 : 0, 1);
        end
        repeat (20) @(negedge clk);
        chk("acc_state_idle", dbg_state, 0);
        clear_q();

        // RD_STATUS
        bus.mlp_state = 4'd3;
        bus.mlp_cycle_cnt = 5'd17;
        send_byte(8'h06, 1'b1);
        wait_frames("stat_frames", 2);
        if (tx_q.size() >= 2) begin
            chk("stat_b0", tx_q[0], 8'h03);
            chk("stat_b1", tx_q[1], 8'h11);
        end
        repeat (20) @(negedge clk);
        clear_q();

        // Framing error: byte dropped, parser stays idle
        rx0 = c_rxv;
        send_byte(8'h01, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr_no_rxv", c_rxv, rx0);
        chk("ferr_state", dbg_state, 0);

        // WF_RESET
        send_byte(8'h08, 1'b1);
        chk("wfrst_cnt", c_wfrst, 1);
        chk("wfrst_wready", bus.weights_ready, 0);
        chk("wfrst_rxv", c_rxv, rx0 + 1);
        chk("wfrst_rx_data", dbg_rx_data, 8'h08);
        settle();
        clear_q();

        // Reset in the middle of a reply
        bus.mlp_acc0 = 32'h12345678;
        send_byte(8'h07, 1'b1);
        for (int i = 0; i < 1000 && tx_q.size() < 1; i++) @(negedge clk);
        chk("mid_first_byte", (tx_q.size() >= 1) ? tx_q[0] : 8'hxx, 8'h12);
        repeat (34) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", uart_tx, 1);
        chk("mid_rst_state", dbg_state, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        clear_q();
        p0 = c_push0;
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b1);
        chk("post_rst_push", c_push0, p0 + 1);
        chk("post_rst_data", last_w0, 8'h77);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
